// File: rtl/resp_chk_pkg.sv
// Shared types and constants for the response checker.
// Holds the FSM state encoding, MISR constants and default widths.
package resp_chk_pkg;

  localparam int unsigned N_IN_DEF  = 3;
  localparam int unsigned OUT_W_DEF = 1;

  localparam int unsigned       MISR_W    = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021; // x^16 + x^12 + x^5 + 1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One Galois-style MISR step: shift, fold feedback, absorb din.
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [MISR_W-1:0] din);
    logic [MISR_W-1:0] fb;
    fb = sig[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}};
    return {sig[MISR_W-2:0], 1'b0} ^ fb ^ din;
  endfunction

endpackage

// File: rtl/resp_checker_if.sv
// Bus between a stimulus/response source and resp_checker.
// Optional signature output present when RESP_CHECKER_MISR_EN is defined.
interface resp_checker_if import resp_chk_pkg::*; #(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
);

  logic               gold_we;
  logic [N_IN-1:0]    gold_addr;
  logic [OUT_W-1:0]   gold_data;
  logic               start;
  logic               vec_valid;
  logic [N_IN-1:0]    vec;
  logic [OUT_W-1:0]   dut_out;

  logic               busy;
  logic               done;
  logic               pass;
  logic [N_IN:0]      mismatch_cnt;
  logic [N_IN:0]      dup_cnt;
  logic [N_IN-1:0]    first_fail_vec;
  logic               first_fail_valid;
`ifdef RESP_CHECKER_MISR_EN
  logic [MISR_W-1:0]  signature;
`endif

  modport master (
    output gold_we, gold_addr, gold_data, start, vec_valid, vec, dut_out,
    input
`ifdef RESP_CHECKER_MISR_EN
          signature,
`endif
          busy, done, pass, mismatch_cnt, dup_cnt, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  gold_we, gold_addr, gold_data, start, vec_valid, vec, dut_out,
    output
`ifdef RESP_CHECKER_MISR_EN
           signature,
`endif
           busy, done, pass, mismatch_cnt, dup_cnt, first_fail_vec, first_fail_valid
  );

endinterface

// File: rtl/resp_misr.sv
// 16-bit multiple-input signature register, seed 0.
// Used by resp_checker only when RESP_CHECKER_MISR_EN is defined.
module resp_misr import resp_chk_pkg::*; (
  input  logic              CK,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  // Signature register: clear takes priority over an update.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_next(sig, din);
    end
  end

endmodule

// File: rtl/resp_checker.sv
// Response checker: compares sampled DUT responses against a golden table,
// tracks coverage of every stimulus vector, counts mismatches and repeats.
// Define RESP_CHECKER_MISR_EN to add a 16-bit response signature (resp_misr).
module resp_checker import resp_chk_pkg::*; #(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic         CK,
  input  logic         reset,
  resp_checker_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** N_IN;
  localparam int unsigned CNT_W = N_IN + 1;

  state_t state, state_next;

  logic [DEPTH-1:0] seen;
  logic [OUT_W-1:0] golden [DEPTH];
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] dup_cnt;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_valid;
  logic             busy, done, pass;

  logic all_seen_c, clr_c, accept_c, gold_wr_c;
  logic new_c, dup_c, miss_c;

  assign all_seen_c = &seen;
  assign new_c      = accept_c & ~seen[bus.vec];
  assign dup_c      = accept_c &  seen[bus.vec];
  assign miss_c     = new_c & (bus.dut_out != golden[bus.vec]);

  // State register.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle controls; the transition cycle accepts nothing.
  always_comb begin
    state_next = state;
    clr_c      = 1'b0;
    accept_c   = 1'b0;
    gold_wr_c  = 1'b0;
    case (state)
      IDLE, DONE: begin
        gold_wr_c = bus.gold_we;
        if (bus.start) begin
          state_next = RUN;
          clr_c      = 1'b1;
        end
      end
      RUN: begin
        if (all_seen_c) state_next = DONE;
        else            accept_c   = bus.vec_valid;
      end
      default: state_next = IDLE;
    endcase
  end

  // Golden response table; writable only outside a pass.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) golden[i] <= '0;
    end else if (gold_wr_c) begin
      golden[bus.gold_addr] <= bus.gold_data;
    end
  end

  // Coverage bitmap, counters and first-failure capture.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      seen             <= '0;
      mismatch_cnt     <= '0;
      dup_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (clr_c) begin
      seen             <= '0;
      mismatch_cnt     <= '0;
      dup_cnt          <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      if (new_c) seen[bus.vec] <= 1'b1;
      if (miss_c) begin
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!first_fail_valid) begin
          first_fail_vec   <= bus.vec;
          first_fail_valid <= 1'b1;
        end
      end
      if (dup_c && (dup_cnt != {CNT_W{1'b1}})) dup_cnt <= dup_cnt + CNT_W'(1);
    end
  end

  // Status flags follow the next state so they line up with the state register.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state == RUN) && (state_next == DONE);
      pass <= (state_next == DONE) && (mismatch_cnt == '0) && (dup_cnt == '0);
    end
  end

  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.mismatch_cnt     = mismatch_cnt;
  assign bus.dup_cnt          = dup_cnt;
  assign bus.first_fail_vec   = first_fail_vec;
  assign bus.first_fail_valid = first_fail_valid;

`ifdef RESP_CHECKER_MISR_EN
  // Signature over every newly covered {vec, dut_out} pair.
  resp_misr u_misr (
    .CK    (CK),
    .reset (reset),
    .clr   (clr_c),
    .en    (new_c),
    .din   (MISR_W'({bus.vec, bus.dut_out})),
    .sig   (bus.signature)
  );
`endif

endmodule

// File: tb/tb_resp_checker.sv
// Self-checking bench for resp_checker (N_IN=3, OUT_W=1).
// Honors RESP_CHECKER_MISR_EN the same way as the design.
module tb_resp_checker;

  localparam int DEPTH = 8;

  logic CK = 1'b0;
  logic reset;

  resp_checker_if #(.N_IN(3), .OUT_W(1)) bus ();

  resp_checker #(.N_IN(3), .OUT_W(1)) dut (
    .CK    (CK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy, m_done, m_pass, m_ffvalid, m_started;
  int m_mm, m_dup, m_ffv, m_sig;
  bit m_seen [DEPTH];
  int m_gold [DEPTH];

  function automatic int model_misr(input int s, input int d);
    int t;
    t = s << 1;
    if ((t & 32'h10000) != 0) t = t ^ 32'h11021;
    return (t ^ d) & 32'hFFFF;
  endfunction

  function automatic int seen_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_seen[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pass = 0; m_ffvalid = 0; m_started = 0;
    m_mm = 0; m_dup = 0; m_ffv = 0; m_sig = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_seen[i] = 0;
      m_gold[i] = 0;
    end
  endtask

  task automatic model_step();
    int v, d;
    v = int'(bus.vec);
    d = int'(bus.dut_out);
    m_done = 0;
    if (m_busy) begin
      if (seen_count() == DEPTH) begin
        m_busy = 0;
        m_done = 1;
        m_pass = (m_mm == 0) && (m_dup == 0);
      end else if (bus.vec_valid) begin
        if (m_seen[v]) begin
          if (m_dup < 15) m_dup++;
        end else begin
          m_seen[v] = 1;
          m_sig = model_misr(m_sig, v * 2 + d);
          if (d != m_gold[v]) begin
            m_mm++;
            if (!m_ffvalid) begin
              m_ffvalid = 1;
              m_ffv     = v;
            end
          end
        end
      end
    end else begin
      if (bus.gold_we) m_gold[int'(bus.gold_addr)] = int'(bus.gold_data);
      if (bus.start) begin
        m_busy = 1; m_pass = 0; m_started = 1;
        m_mm = 0; m_dup = 0; m_ffvalid = 0; m_sig = 0;
        for (int i = 0; i < DEPTH; i++) m_seen[i] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CK or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_seen = 0;

  initial begin
    forever begin
      @(negedge CK);
      check("busy",     32'(bus.busy),             32'(m_busy));
      check("done",     32'(bus.done),             32'(m_done));
      check("pass",     32'(bus.pass),             32'(m_pass));
      check("mism_cnt", 32'(bus.mismatch_cnt),     32'(m_mm));
      check("dup_cnt",  32'(bus.dup_cnt),          32'(m_dup));
      check("ff_valid", 32'(bus.first_fail_valid), 32'(m_ffvalid));
      if (m_ffvalid || !m_started) check("ff_vec", 32'(bus.first_fail_vec), 32'(m_ffv));
`ifdef RESP_CHECKER_MISR_EN
      check("signature", 32'(bus.signature), 32'(m_sig));
`endif
      if (bus.done === 1'b1) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CK);
    #2;
  endtask

  function automatic int xr(input int v);
    return v[0] ^ v[1] ^ v[2];
  endfunction

  task automatic apply(input int v, input int d);
    bus.vec_valid = 1'b1;
    bus.vec       = 3'(v);
    bus.dut_out   = 1'(d);
    step();
    bus.vec_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic load_xor3();
    for (int a = 0; a < DEPTH; a++) begin
      bus.gold_we   = 1'b1;
      bus.gold_addr = 3'(a);
      bus.gold_data = 1'(xr(a));
      step();
    end
    bus.gold_we = 1'b0;
  endtask

  int base;
  logic [31:0] sig_a, sig_b;

  initial begin
    reset = 1'b1;
    bus.gold_we = 0; bus.gold_addr = 0; bus.gold_data = 0;
    bus.start = 0; bus.vec_valid = 0; bus.vec = 0; bus.dut_out = 0;
    sig_a = 0; sig_b = 0;
    step(); step();

    // model pins
    check("pin_misr_din", 32'(model_misr(0, 5)), 32'd5);
    check("pin_misr_fb",  32'(model_misr(32'h8000, 0)), 32'h1021);

    // reset state
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pass", 32'(bus.pass), 0);
    check("rst_mm",   32'(bus.mismatch_cnt), 0);
    check("rst_ffv",  32'(bus.first_fail_vec), 0);
    reset = 1'b0;
    step();

    // 1: all match in order
    load_xor3();
    base = done_seen;
    do_start();
    check("s1_busy", 32'(bus.busy), 1);
    for (int v = 0; v < DEPTH; v++) apply(v, xr(v));
    step(); step(); step();
    check("s1_done_once", 32'(done_seen - base), 1);
    check("s1_pass", 32'(bus.pass), 1);
    check("s1_mm",   32'(bus.mismatch_cnt), 0);
    check("s1_dup",  32'(bus.dup_cnt), 0);
`ifdef RESP_CHECKER_MISR_EN
    sig_a = 32'(bus.signature);
`endif

    // 2: response at 101 inverted
    base = done_seen;
    do_start();
    for (int v = 0; v < DEPTH; v++) apply(v, (v == 5) ? 1 - xr(v) : xr(v));
    step(); step();
    check("s2_mm",   32'(bus.mismatch_cnt), 1);
    check("s2_ffv",  32'(bus.first_fail_vec), 5);
    check("s2_ffvl", 32'(bus.first_fail_valid), 1);
    check("s2_pass", 32'(bus.pass), 0);
    check("s2_done_once", 32'(done_seen - base), 1);

    // 3: 011 twice; vector in the transition cycle is ignored
    base = done_seen;
    do_start();
    apply(3, xr(3)); apply(3, xr(3));
    apply(0, 0); apply(1, 1); apply(2, 1); apply(4, 1); apply(5, 0); apply(6, 0);
    step(); step();
    check("s3_no_done", 32'(done_seen - base), 0);
    check("s3_busy",    32'(bus.busy), 1);
    apply(7, 1);
    apply(3, xr(3));
    step(); step();
    check("s3_dup",  32'(bus.dup_cnt), 1);
    check("s3_pass", 32'(bus.pass), 0);
    check("s3_done_once", 32'(done_seen - base), 1);

    // 4: dup counter saturation
    base = done_seen;
    do_start();
    for (int k = 0; k < 18; k++) apply(0, 0);
    check("s4_dup_sat", 32'(bus.dup_cnt), 15);
    for (int v = 1; v < DEPTH; v++) apply(v, xr(v));
    step(); step();
    check("s4_dup_hold", 32'(bus.dup_cnt), 15);
    check("s4_done_once", 32'(done_seen - base), 1);

    // 5: reset mid-pass, then a full pass against the cleared table
    base = done_seen;
    do_start();
    for (int v = 0; v < 4; v++) apply(v, xr(v));
    reset = 1'b1;
    step();
    check("s5_busy", 32'(bus.busy), 0);
    check("s5_mm",   32'(bus.mismatch_cnt), 0);
    check("s5_dup",  32'(bus.dup_cnt), 0);
    reset = 1'b0;
    step(); step();
    check("s5_no_done", 32'(done_seen - base), 0);
    base = done_seen;
    do_start();
    for (int v = 0; v < DEPTH; v++) apply(v, 0);
    step(); step();
    check("s5_pass", 32'(bus.pass), 1);
    check("s5_done_once", 32'(done_seen - base), 1);

    // 6: table write and start during RUN are ignored; vec_valid in DONE ignored
    load_xor3();
    base = done_seen;
    do_start();
    bus.gold_we = 1'b1; bus.gold_addr = 3'd0; bus.gold_data = 1'b1;
    bus.start = 1'b1;
    step();
    bus.gold_we = 1'b0; bus.start = 1'b0;
    for (int v = 0; v < DEPTH; v++) apply(v, xr(v));
    step(); step();
    check("s6_pass", 32'(bus.pass), 1);
    check("s6_mm",   32'(bus.mismatch_cnt), 0);
    apply(5, 0);
    step();
    check("s6_done_mm",   32'(bus.mismatch_cnt), 0);
    check("s6_done_pass", 32'(bus.pass), 1);
    check("s6_done_once", 32'(done_seen - base), 1);

`ifdef RESP_CHECKER_MISR_EN
    // 7: reverse order gives a different signature
    do_start();
    for (int v = DEPTH - 1; v >= 0; v--) apply(v, xr(v));
    step(); step();
    sig_b = 32'(bus.signature);
    check("misr_differ", 32'(sig_a != sig_b), 1);
    check("misr_model_rev", sig_b, 32'(m_sig));
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/resp_checker.md
RESP_CHECKER -- requirements
Module: resp_checker

Interface
REQ-001 Parameter N_IN, default 3: stimulus vector width; the table depth is 2**N_IN.
REQ-002 Parameter OUT_W, default 1: DUT response width.
REQ-003 Port CK  input  1: single clock; all state updates on posedge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port gold_we  input  1: golden-table write strobe; honoured only in IDLE or DONE.
REQ-006 Port gold_addr  input  N_IN: golden-table write address (the stimulus vector value).
REQ-007 Port gold_data  input  OUT_W: expected response for gold_addr.
REQ-008 Port start  input  1: begins a check pass.
REQ-009 Port vec_valid  input  1: vec/dut_out pair is valid this cycle.
REQ-010 Port vec  input  N_IN: applied stimulus vector N.
REQ-011 Port dut_out  input  OUT_W: sampled DUT response for vec.
REQ-012 Port busy  output  1: high in RUN.
REQ-013 Port done  output  1: one-cycle pulse on entry to DONE.
REQ-014 Port pass  output  1: high in DONE when mismatch_cnt==0 and dup_cnt==0.
REQ-015 Port mismatch_cnt  output  N_IN+1: number of vectors whose response differed from golden.
REQ-016 Port dup_cnt  output  N_IN+1: number of repeated vectors; saturates at all-ones.
REQ-017 Port first_fail_vec  output  N_IN: vec value of the first mismatch.
REQ-018 Port first_fail_valid  output  1: first_fail_vec holds a valid value.

Function
REQ-019 FSM states are IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE in the cycle after the last unseen vector is accepted; DONE->RUN on start; no other transitions.
REQ-020 Entering RUN clears the seen bitmap (2**N_IN bits), mismatch_cnt, dup_cnt, first_fail_valid and the signature; the golden table is not cleared.
REQ-021 In RUN, vec_valid with vec unseen: set seen[vec]; increment mismatch_cnt if dut_out != golden[vec] (full OUT_W compare).
REQ-022 In RUN, vec_valid with vec already seen: increment dup_cnt; mismatch_cnt, the seen bitmap and first_fail are unchanged.
REQ-023 On the first mismatch of a pass, capture vec into first_fail_vec and set first_fail_valid; later mismatches do not overwrite it.
REQ-024 vec_valid outside RUN is ignored; start while in RUN is ignored.
REQ-025 Vectors are accepted in any order; acceptance latency is 1 cycle (counters are visible the cycle after vec_valid).
REQ-026 A vec_valid that coincides with the RUN->DONE transition cycle is ignored.
REQ-027 gold_we in RUN is ignored; the table is unchanged.
REQ-028 Counters never wrap: mismatch_cnt is at most 2**N_IN by construction; dup_cnt saturates.

Reset
REQ-029 Asserting reset puts the FSM in IDLE and forces busy=0, done=0, pass=0, all counters=0, first_fail_vec=0, first_fail_valid=0, signature=0 and the bitmap to all zeros.
REQ-030 The golden table resets to all zeros; reset mid-RUN abandons the pass without asserting done.

Configuration
REQ-031 With RESP_CHECKER_MISR_EN defined, output signature (16 bits) is a MISR with polynomial x^16+x^12+x^5+1 and seed 0, updated on every accepted unseen vector with {vec,dut_out} zero-extended to 16 bits.
REQ-032 Without RESP_CHECKER_MISR_EN, the signature port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Package resp_chk_pkg holds the FSM state enum, the MISR polynomial and width constants, and the default N_IN/OUT_W values.
REQ-034 The MISR is the sub-module resp_misr (CK, reset, clr, en, din, sig), instantiated only under RESP_CHECKER_MISR_EN.

Verification
REQ-035 Load golden = XOR3 truth table; start; apply 000..111 in order with dut_out matching -> done pulses once, pass=1, mismatch_cnt=0, dup_cnt=0.
REQ-036 Same table; dut_out at vec=101 inverted -> mismatch_cnt=1, first_fail_vec=101, first_fail_valid=1, pass=0.
REQ-037 Apply 011 twice, then the remaining 7 vectors -> dup_cnt=1, done only after all 8 distinct vectors, pass=0.
REQ-038 Assert reset after 4 vectors -> busy=0, counters=0, no done pulse; restart with all 8 vectors -> pass=1.
REQ-039 gold_we during RUN at addr 000 with flipped data -> table unchanged; a matching response still passes.
REQ-040 With RESP_CHECKER_MISR_EN, in-order and reverse-order passes with identical responses -> signatures differ, and each matches the reference-model value.
